// File: rtl/key_pkg.sv
// Shared key definitions for the Tic-Tac-Toe serial link.
// Both the transmit-side encoder and the receive-side decoder use this
// package, so the two ends agree on byte values and key ordering.
package key_pkg;

  // ASCII codes carried on the link.
  localparam logic [7:0] KEY_W     = 8'h77;  // up
  localparam logic [7:0] KEY_S     = 8'h73;  // down
  localparam logic [7:0] KEY_A     = 8'h61;  // left
  localparam logic [7:0] KEY_D     = 8'h64;  // right
  localparam logic [7:0] KEY_SPACE = 8'h20;  // space
  localparam logic [7:0] KEY_ENTER = 8'h0D;  // enter (CR)

  // Key index. The order is also the arbitration priority (lowest wins).
  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    LEFT  = 3'd2,
    RIGHT = 3'd3,
    SPACE = 3'd4,
    ENTER = 3'd5
  } key_idx_e;

  localparam int NUM_KEYS = 6;

  // Default per-key lockout after an accepted press (10 ms at 50 MHz).
  localparam int COOLDOWN_CYCLES_DEFAULT = 500000;

  // Width of each cooldown down-counter; holds up to 1,048,575.
  localparam int COOLDOWN_W = 20;

  // Map a key index to the byte sent on the link.
  function automatic logic [7:0] key_code(input logic [2:0] idx);
    logic [7:0] code;
    code = 8'h00;
    case (idx)
      UP:      code = KEY_W;
      DOWN:    code = KEY_S;
      LEFT:    code = KEY_A;
      RIGHT:   code = KEY_D;
      SPACE:   code = KEY_SPACE;
      ENTER:   code = KEY_ENTER;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO. Pointers carry one extra wrap bit so that
// full (same address, different wrap) and empty (identical pointers)
// are distinguishable without a separate flag. A push into a full FIFO
// is refused even when a pop happens in the same cycle; the caller is
// expected to detect that case through the full output.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = count_q;

  // Head entry is forced to zero while empty so the output reads 0 after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

  // Qualify requests against full/empty and compute next pointers and occupancy.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because empty masks the read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/key_encoder.sv
// Turns debounced button levels into link key bytes. Each key has a
// rising-edge detector and a lockout counter; accepted presses set a
// pending bit, a fixed-priority arbiter moves one pending key per cycle
// into a byte FIFO, and the FIFO feeds the UART over valid/ready.
module key_encoder
  import key_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          up,
  input  logic                          down,
  input  logic                          left,
  input  logic                          right,
  input  logic                          enter,
  input  logic                          space,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [COOLDOWN_W-1:0] COOLDOWN_LOAD = COOLDOWN_W'(COOLDOWN_CYCLES);

  logic [NUM_KEYS-1:0]   level;
  logic [NUM_KEYS-1:0]   prev_q, prev_d;
  logic [NUM_KEYS-1:0]   pending_q, pending_d;
  logic [NUM_KEYS-1:0]   key_edge;
  logic [NUM_KEYS-1:0]   accept;
  logic [NUM_KEYS-1:0]   grant;
  logic [COOLDOWN_W-1:0] cooldown_q [NUM_KEYS];
  logic [COOLDOWN_W-1:0] cooldown_d [NUM_KEYS];
  logic                  push;
  logic [7:0]            push_code;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  overflow_q, overflow_d;

  // Key vector in priority order.
  assign level[UP]    = up;
  assign level[DOWN]  = down;
  assign level[LEFT]  = left;
  assign level[RIGHT] = right;
  assign level[SPACE] = space;
  assign level[ENTER] = enter;

  // Rising-edge detect and per-key lockout: only an edge seen while the
  // counter is idle is accepted, and it restarts the lockout.
  always_comb begin
    key_edge = level & ~prev_q;
    prev_d   = level;
    accept   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cooldown_d[i] = cooldown_q[i];
      accept[i]     = key_edge[i] && (cooldown_q[i] == '0);
      if (accept[i]) begin
        cooldown_d[i] = COOLDOWN_LOAD;
      end else if (cooldown_q[i] != '0) begin
        cooldown_d[i] = cooldown_q[i] - COOLDOWN_W'(1);
      end
    end
  end

  // Fixed-priority arbiter: the lowest-index pending key is pushed this cycle.
  always_comb begin
    grant     = '0;
    push      = 1'b0;
    push_code = 8'h00;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!push && pending_q[i]) begin
        grant[i]  = 1'b1;
        push      = 1'b1;
        push_code = key_code(3'(i));
      end
    end
  end

  // Pending update and overflow detection. A granted key is cleared even
  // when its byte is dropped; a new acceptance is merged in afterwards.
  always_comb begin
    pending_d  = (pending_q & ~grant) | accept;
    overflow_d = push & fifo_full;
  end

  // Edge-detect, lockout, pending and overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cooldown_q[i] <= '0;
      end
    end else begin
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cooldown_q[i] <= cooldown_d[i];
      end
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_code),
    .pop       (tx_ready),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_valid = ~fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_encoder.sv
// Bench for key_encoder: directed scenarios followed by random key and
// ready activity. A cycle-stepped behavioural model (timestamps for the
// lockout, a queue for the FIFO) pushes expected bytes into a scoreboard;
// an independent monitor pops and compares on every DUT transfer.
module tb_key_encoder;

  localparam int DEPTH = 4;
  localparam int CD    = 40;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic [5:0]    keys     = '0;   // 0 up,1 down,2 left,3 right,4 space,5 enter
  logic          tx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  key_encoder #(
    .FIFO_DEPTH      (DEPTH),
    .COOLDOWN_CYCLES (CD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .up         (keys[0]),
    .down       (keys[1]),
    .left       (keys[2]),
    .right      (keys[3]),
    .space      (keys[4]),
    .enter      (keys[5]),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_xfer = 0;
  int n_ovf  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned code_tab [6] = '{8'h77, 8'h73, 8'h61, 8'h64, 8'h20, 8'h0D};
  bit           m_prev  [6];
  bit           m_pend  [6];
  longint       m_ready [6];   // first cycle at which a new press is accepted
  byte unsigned m_fifo  [$];
  byte unsigned sb      [$];
  bit           m_ovf;
  longint       cyc = 0;
  int           m_old;
  bit           m_found;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) begin
        m_prev[k]  = 1'b0;
        m_pend[k]  = 1'b0;
        m_ready[k] = 0;
      end
      m_fifo.delete();
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      m_old = m_fifo.size();
      if (m_old > 0 && tx_ready) void'(m_fifo.pop_front());
      m_ovf   = 1'b0;
      m_found = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (!m_found && m_pend[k]) begin
          m_found   = 1'b1;
          m_pend[k] = 1'b0;
          if (m_old < DEPTH) begin
            m_fifo.push_back(code_tab[k]);
            sb.push_back(code_tab[k]);
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      for (int k = 0; k < 6; k++) begin
        if (keys[k] && !m_prev[k] && cyc >= m_ready[k]) begin
          m_pend[k]  = 1'b1;
          m_ready[k] = cyc + CD + 1;
        end
        m_prev[k] = keys[k];
      end
      cyc++;
    end
  end

  // ---------------- monitor ----------------
  bit         hold_valid = 1'b0;
  logic [7:0] hold_data  = '0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("fifo_count", 32'(fifo_count), 32'(m_fifo.size()));
      chk("tx_valid", 32'(tx_valid), 32'(m_fifo.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (overflow) n_ovf++;
      if (hold_valid && tx_valid) chk("tx_data_stable", 32'(tx_data), 32'(hold_data));
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %02h want none (t=%0t)", tx_data, $time);
        end else begin
          chk("tx_data", 32'(tx_data), 32'(sb.pop_front()));
          n_xfer++;
          $display("xfer %0d: byte %02h", n_xfer, tx_data);
        end
      end
      hold_valid = tx_valid && !tx_ready;
      hold_data  = tx_data;
    end else begin
      hold_valid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int x0;
  int ov0;
  int t;

  initial begin
    tick(3);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;

    // Single press held 3 cycles: exactly one byte.
    x0 = n_xfer;
    tx_ready = 1'b1;
    keys = 6'b000001;
    tick(3);
    keys = '0;
    tick(10);
    chk("single_press_count", 32'(n_xfer - x0), 1);

    // Simultaneous up/left/enter: three bytes in priority order.
    tick(CD);
    x0 = n_xfer;
    keys = 6'b100101;
    tick(2);
    keys = '0;
    tick(10);
    chk("simul_press_count", 32'(n_xfer - x0), 3);

    // Second right press inside the lockout is ignored; later one is accepted.
    tick(CD);
    x0 = n_xfer;
    keys = 6'b001000; tick(2); keys = '0; tick(10);
    keys = 6'b001000; tick(2); keys = '0; tick(10);
    chk("cooldown_block", 32'(n_xfer - x0), 1);
    tick(CD);
    keys = 6'b001000; tick(2); keys = '0; tick(10);
    chk("cooldown_expire", 32'(n_xfer - x0), 2);

    // Five keys with the sink stalled: FIFO fills, one byte dropped.
    tick(CD);
    ov0 = n_ovf;
    tx_ready = 1'b0;
    keys = 6'b011111;
    tick(2);
    keys = '0;
    tick(8);
    chk("full_count", 32'(fifo_count), 4);
    chk("full_head", 32'(tx_data), 32'h77);
    chk("overflow_pulses", 32'(n_ovf - ov0), 1);
    tx_ready = 1'b1;
    tick(8);
    chk("drained_valid", 32'(tx_valid), 0);

    // Reset with three bytes queued, then an immediate press.
    tick(CD);
    tx_ready = 1'b0;
    keys = 6'b000111;
    tick(2);
    keys = '0;
    tick(6);
    chk("pre_reset_count", 32'(fifo_count), 3);
    reset = 1'b1;
    #2;
    chk("reset_tx_valid", 32'(tx_valid), 0);
    chk("reset_fifo_count", 32'(fifo_count), 0);
    chk("reset_tx_data", 32'(tx_data), 0);
    tick(1);
    reset = 1'b0;
    x0 = n_xfer;
    tx_ready = 1'b1;
    keys = 6'b000001;
    tick(2);
    keys = '0;
    tick(6);
    chk("post_reset_press", 32'(n_xfer - x0), 1);

    // Push and pop in the same cycle at 3 entries.
    tick(CD);
    tx_ready = 1'b0;
    keys = 6'b000111;
    tick(2);
    keys = '0;
    tick(6);
    keys = 6'b001000;     // sampled at next edge, pushed the edge after
    tick(1);
    keys = '0;
    tx_ready = 1'b1;      // pop coincides with the push
    tick(1);
    tx_ready = 1'b0;
    chk("push_pop_count", 32'(fifo_count), 3);
    tx_ready = 1'b1;
    tick(8);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 5) == 0) keys[k] = ~keys[k];
      end
      if ((i / 200) % 2 == 0) tx_ready = ($urandom_range(0, 3) != 0);
      else                    tx_ready = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end else begin
        tick(1);
      end
    end

    // Final drain with a bounded wait.
    keys = '0;
    tx_ready = 1'b1;
    t = 0;
    while ((tx_valid || sb.size() != 0) && t < 200) begin
      tick(1);
      t++;
    end
    chk("final_sb_empty", 32'(sb.size()), 0);
    chk("final_tx_valid", 32'(tx_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
